// File: rtl/divisor_de_inmediato_pkg.sv
// rtl/divisor_de_inmediato_pkg.sv - shared constants and state encoding for immediate splitting
package pkg_inmediatos;

    localparam logic TIPO_ADDI = 1'b0;
    localparam logic TIPO_LUI  = 1'b1;

    localparam logic BASE_X0 = 1'b0;
    localparam logic BASE_RD = 1'b1;

    localparam int          ANCHO_BAJO = 12;
    localparam logic [31:0] REDONDEO   = 32'h0000_0800;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_UNICO = 2'd1,
        EMIT_LUI   = 2'd2,
        EMIT_ADDI  = 2'd3
    } estado_t;

endpackage

// File: rtl/divisor_de_inmediato_clasificador.sv
// rtl/divisor_de_inmediato_clasificador.sv - combinational split of a constant into hi/lo fields
module clasificador_de_inmediato
    import pkg_inmediatos::*;
(
    input  logic [31:0] valor,
    output logic        cabe12,
    output logic        bajo_cero,
    output logic [19:0] hi,
    output logic [11:0] lo
);

    logic [31:0] suma;

    // Rounding by 0x800 pre-compensates the sign extension of the low field.
    // Adding 0x800 leaves exactly 0x800 in the low field only when it was zero.
    always_comb begin
        suma      = valor + REDONDEO;
        cabe12    = (valor[31:ANCHO_BAJO-1] == {21{valor[ANCHO_BAJO-1]}});
        bajo_cero = (suma[ANCHO_BAJO-1:0] == REDONDEO[ANCHO_BAJO-1:0]);
        hi        = suma[31:ANCHO_BAJO];
        lo        = valor[ANCHO_BAJO-1:0];
    end

endmodule

// File: rtl/divisor_de_inmediato.sv
// rtl/divisor_de_inmediato.sv - emits ADDI/LUI pieces rebuilding a 32-bit constant
module divisor_de_inmediato
    import pkg_inmediatos::*;
#(
    parameter int ANCHO_DATO   = 32,
    parameter int ANCHO_CUENTA = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ANCHO_DATO-1:0]   valor,
    input  logic [4:0]              rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_tipo,
    output logic [19:0]             out_inmediato,
    output logic                    out_base,
    output logic [4:0]              out_rd,
    output logic                    out_ultimo,
    output logic [ANCHO_CUENTA-1:0] cuenta_pares
);

    estado_t estado_q, estado_d;

    logic                    out_valid_q, out_valid_d;
    logic                    out_tipo_q, out_tipo_d;
    logic [19:0]             out_inmediato_q, out_inmediato_d;
    logic                    out_base_q, out_base_d;
    logic [4:0]              out_rd_q, out_rd_d;
    logic                    out_ultimo_q, out_ultimo_d;
    logic [11:0]             lo_q, lo_d;
    logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;

    logic        cabe12, bajo_cero;
    logic [19:0] hi;
    logic [11:0] lo;
    logic        acepta, entrega;

    clasificador_de_inmediato u_clasificador (
        .valor     (valor),
        .cabe12    (cabe12),
        .bajo_cero (bajo_cero),
        .hi        (hi),
        .lo        (lo)
    );

    assign in_ready = (estado_q == IDLE) && !rst;
    assign acepta   = in_valid && in_ready;
    assign entrega  = out_valid_q && out_ready;

    // State and output registers; reset discards any pending piece and the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q        <= IDLE;
            out_valid_q     <= 1'b0;
            out_tipo_q      <= TIPO_ADDI;
            out_inmediato_q <= '0;
            out_base_q      <= BASE_X0;
            out_rd_q        <= '0;
            out_ultimo_q    <= 1'b0;
            lo_q            <= '0;
            cuenta_q        <= '0;
        end else begin
            estado_q        <= estado_d;
            out_valid_q     <= out_valid_d;
            out_tipo_q      <= out_tipo_d;
            out_inmediato_q <= out_inmediato_d;
            out_base_q      <= out_base_d;
            out_rd_q        <= out_rd_d;
            out_ultimo_q    <= out_ultimo_d;
            lo_q            <= lo_d;
            cuenta_q        <= cuenta_d;
        end
    end

    // Next state: single pieces return to IDLE after one handshake, pairs go LUI then ADDI.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:       if (acepta)  estado_d = (cabe12 || bajo_cero) ? EMIT_UNICO : EMIT_LUI;
            EMIT_UNICO: if (entrega) estado_d = IDLE;
            EMIT_LUI:   if (entrega) estado_d = EMIT_ADDI;
            EMIT_ADDI:  if (entrega) estado_d = IDLE;
            default:    estado_d = IDLE;
        endcase
    end

    // Output fields: load the first piece on acceptance, the ADDI on the LUI handshake, hold otherwise.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_tipo_d      = out_tipo_q;
        out_inmediato_d = out_inmediato_q;
        out_base_d      = out_base_q;
        out_rd_d        = out_rd_q;
        out_ultimo_d    = out_ultimo_q;
        lo_d            = lo_q;
        cuenta_d        = cuenta_q;
        case (estado_q)
            IDLE: begin
                if (acepta) begin
                    out_valid_d = 1'b1;
                    out_rd_d    = rd;
                    out_base_d  = BASE_X0;
                    lo_d        = lo;
                    if (cabe12) begin
                        out_tipo_d      = TIPO_ADDI;
                        out_inmediato_d = {8'h00, lo};
                        out_ultimo_d    = 1'b1;
                    end else if (bajo_cero) begin
                        out_tipo_d      = TIPO_LUI;
                        out_inmediato_d = hi;
                        out_ultimo_d    = 1'b1;
                    end else begin
                        out_tipo_d      = TIPO_LUI;
                        out_inmediato_d = hi;
                        out_ultimo_d    = 1'b0;
                        cuenta_d        = cuenta_q + 1'b1;
                    end
                end
            end
            EMIT_LUI: begin
                if (entrega) begin
                    out_tipo_d      = TIPO_ADDI;
                    out_inmediato_d = {8'h00, lo_q};
                    out_base_d      = BASE_RD;
                    out_ultimo_d    = 1'b1;
                end
            end
            EMIT_UNICO, EMIT_ADDI: begin
                if (entrega) out_valid_d = 1'b0;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    assign out_valid     = out_valid_q;
    assign out_tipo      = out_tipo_q;
    assign out_inmediato = out_inmediato_q;
    assign out_base      = out_base_q;
    assign out_rd        = out_rd_q;
    assign out_ultimo    = out_ultimo_q;
    assign cuenta_pares  = cuenta_q;

endmodule

// File: tb/tb_divisor_de_inmediato.sv
// tb/tb_divisor_de_inmediato.sv - scoreboard bench for divisor_de_inmediato
module tb_divisor_de_inmediato;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] valor = '0;
    logic [4:0]  rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_tipo;
    logic [19:0] out_inmediato;
    logic        out_base;
    logic [4:0]  out_rd;
    logic        out_ultimo;
    logic [15:0] cuenta_pares;

    divisor_de_inmediato dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .valor         (valor),
        .rd            (rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_tipo      (out_tipo),
        .out_inmediato (out_inmediato),
        .out_base      (out_base),
        .out_rd        (out_rd),
        .out_ultimo    (out_ultimo),
        .cuenta_pares  (cuenta_pares)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tipo;
        logic [19:0] inm;
        logic        base;
        logic [4:0]  rd;
        logic        ultimo;
        logic [31:0] valor;
    } pieza_t;

    pieza_t      sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_pares = 0;
    logic [31:0] acc = '0;

    task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nombre, got, exp);
        end
    endtask

    task automatic expect_piece(input logic tipo, input logic [19:0] inm, input logic base,
                                input logic [4:0] r, input logic ult, input logic [31:0] v);
        pieza_t p;
        p.tipo = tipo; p.inm = inm; p.base = base; p.rd = r; p.ultimo = ult; p.valor = v;
        sb.push_back(p);
    endtask

    // Independent model: hi is derived by subtracting the sign-extended low field.
    task automatic expect_model(input logic [31:0] v, input logic [4:0] r);
        logic [31:0] slo, resto;
        slo   = {{20{v[11]}}, v[11:0]};
        resto = v - slo;
        if (v[31:11] == {21{v[11]}}) begin
            expect_piece(1'b0, {8'h00, v[11:0]}, 1'b0, r, 1'b1, v);
        end else if (v[11:0] == 12'h000) begin
            expect_piece(1'b1, v[31:12], 1'b0, r, 1'b1, v);
        end else begin
            expect_piece(1'b1, resto[31:12], 1'b0, r, 1'b0, v);
            expect_piece(1'b0, {8'h00, v[11:0]}, 1'b1, r, 1'b1, v);
            exp_pares++;
        end
    endtask

    // Monitor: pops and compares one expected piece per observed handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_piece: got tipo=%0b inm=%h with empty scoreboard", out_tipo, out_inmediato);
            end else begin
                pieza_t e, g;
                e = sb.pop_front();
                g.tipo = out_tipo; g.inm = out_inmediato; g.base = out_base;
                g.rd = out_rd; g.ultimo = out_ultimo; g.valor = e.valor;
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL piece(%h): got tipo=%0b inm=%h base=%0b rd=%0d ult=%0b expected tipo=%0b inm=%h base=%0b rd=%0d ult=%0b",
                             e.valor, g.tipo, g.inm, g.base, g.rd, g.ultimo, e.tipo, e.inm, e.base, e.rd, e.ultimo);
                end
                if (out_tipo) acc = {out_inmediato, 12'h000};
                else acc = (out_base ? acc : 32'h0) + {{20{out_inmediato[11]}}, out_inmediato[11:0]};
                if (out_ultimo) check("reconstruccion", acc, e.valor);
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [4:0] r);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for %h", v);
        end else begin
            valor = v; rd = r; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            valor = $urandom;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    logic [31:0] extra[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_07FF,
                              32'hFFFF_F7FF, 32'hDEAD_BEEF, 32'h0000_1800};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cuenta", cuenta_pares, 0);
        check("rst_fields", {out_tipo, out_inmediato, out_base, out_rd, out_ultimo}, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        expect_piece(1'b0, 20'h00800, 1'b0, 5'd5, 1'b1, 32'hFFFF_F800);
        send(32'hFFFF_F800, 5'd5);
        drain();
        check("cuenta_after_fits", cuenta_pares, 0);

        expect_piece(1'b1, 20'h12345, 1'b0, 5'd7, 1'b1, 32'h1234_5000);
        send(32'h1234_5000, 5'd7);
        expect_piece(1'b1, 20'h00001, 1'b0, 5'd1, 1'b0, 32'h0000_0800);
        expect_piece(1'b0, 20'h00800, 1'b1, 5'd1, 1'b1, 32'h0000_0800);
        send(32'h0000_0800, 5'd1);
        expect_piece(1'b1, 20'h80000, 1'b0, 5'd31, 1'b0, 32'h7FFF_FFFF);
        expect_piece(1'b0, 20'h00FFF, 1'b1, 5'd31, 1'b1, 32'h7FFF_FFFF);
        send(32'h7FFF_FFFF, 5'd31);
        expect_piece(1'b0, 20'h00000, 1'b0, 5'd2, 1'b1, 32'h0000_0000);
        send(32'h0000_0000, 5'd2);
        drain();
        check("cuenta_after_pairs", cuenta_pares, 2);

        // Backpressure on the LUI piece
        out_ready = 1'b0;
        expect_piece(1'b1, 20'h00001, 1'b0, 5'd9, 1'b0, 32'h0000_0800);
        expect_piece(1'b0, 20'h00800, 1'b1, 5'd9, 1'b1, 32'h0000_0800);
        send(32'h0000_0800, 5'd9);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_fields", {out_valid, out_tipo, out_inmediato, out_base, out_rd, out_ultimo},
                  {1'b1, 1'b1, 20'h00001, 1'b0, 5'd9, 1'b0});
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_addi_next", {out_valid, out_tipo, out_base, out_ultimo}, 4'b1011);
        drain();
        check("cuenta_after_bp", cuenta_pares, 3);

        // Reset while the LUI of a pair is pending
        out_ready = 1'b0;
        expect_model(32'h1234_5678, 5'd4);
        send(32'h1234_5678, 5'd4);
        check("midrst_lui_pending", {out_valid, out_tipo}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        exp_pares = 0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cuenta", cuenta_pares, 0);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_addi", out_valid, 0);

        foreach (extra[i]) begin
            expect_model(extra[i], 5'(i + 10));
            send(extra[i], 5'(i + 10));
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            expect_model(v, 5'($urandom_range(0, 31)));
            send(v, sb[sb.size() - 1].rd);
        end
        drain();
        check("cuenta_final", cuenta_pares, exp_pares[15:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
